// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the Viterbi decoder: symbol intake with ACS enables,
// pipeline flush, then traceback from the last survivor back to the first.
module viterbi_ctrl #(
   parameter int CNT_W   = 8,
   parameter int ACS_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_frame_len,
   input  logic             i_sym_valid,
   output logic             o_sym_ready,
   output logic             o_en_acs,
   output logic             o_first_sym,
   output logic             o_mem_wr_en,
   output logic [CNT_W-1:0] o_mem_wr_addr,
   output logic             o_en_tb,
   output logic [CNT_W-1:0] o_tb_addr,
   output logic             o_busy,
   output logic             o_done
);

   localparam int FL_W = (ACS_LAT > 1) ? $clog2(ACS_LAT) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ACS   = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_TB    = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] sym_cnt;
   logic [CNT_W-1:0] tb_cnt;
   logic [FL_W-1:0]  flush_cnt;
   logic             accept;

   assign accept = (state == S_ACS) && i_sym_valid;

   // NOTE: every register here, counters included, is cleared by reset so an
   // aborted frame can never leak a stale address into the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         state     <= S_IDLE;
         len_q     <= '0;
         sym_cnt   <= '0;
         tb_cnt    <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start && (i_frame_len != '0)) begin
                  len_q   <= i_frame_len;
                  sym_cnt <= '0;
                  state   <= S_ACS;
               end
            end
            S_ACS: begin
               if (accept) begin
                  sym_cnt <= sym_cnt + 1'b1;
                  if (sym_cnt == len_q - 1'b1) begin
                     flush_cnt <= '0;
                     state     <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_cnt == FL_W'(ACS_LAT - 1)) begin
                  tb_cnt <= len_q - 1'b1;
                  state  <= S_TB;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            S_TB: begin
               // Stop at zero rather than decrementing, so the counter never wraps.
               if (tb_cnt == '0) begin
                  state <= S_DONE;
               end else begin
                  tb_cnt <= tb_cnt - 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_sym_ready   = (state == S_ACS);
   assign o_en_acs      = accept;
   assign o_mem_wr_en   = accept;
   assign o_first_sym   = accept && (sym_cnt == '0);
   assign o_mem_wr_addr = accept ? sym_cnt : '0;
   assign o_en_tb       = (state == S_TB);
   assign o_tb_addr     = (state == S_TB) ? tb_cnt : '0;
   assign o_busy        = (state != S_IDLE);
   assign o_done        = (state == S_DONE);

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed self-checking bench for viterbi_ctrl (CNT_W=8, ACS_LAT=1).
// Inputs change and outputs are sampled on the falling edge.
module tb_viterbi_ctrl;

   localparam int CNT_W   = 8;
   localparam int ACS_LAT = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_start;
   logic [CNT_W-1:0] i_frame_len;
   logic             i_sym_valid;
   logic             o_sym_ready;
   logic             o_en_acs;
   logic             o_first_sym;
   logic             o_mem_wr_en;
   logic [CNT_W-1:0] o_mem_wr_addr;
   logic             o_en_tb;
   logic [CNT_W-1:0] o_tb_addr;
   logic             o_busy;
   logic             o_done;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   viterbi_ctrl #(.CNT_W(CNT_W), .ACS_LAT(ACS_LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_frame_len   (i_frame_len),
      .i_sym_valid   (i_sym_valid),
      .o_sym_ready   (o_sym_ready),
      .o_en_acs      (o_en_acs),
      .o_first_sym   (o_first_sym),
      .o_mem_wr_en   (o_mem_wr_en),
      .o_mem_wr_addr (o_mem_wr_addr),
      .o_en_tb       (o_en_tb),
      .o_tb_addr     (o_tb_addr),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " ready"},   o_sym_ready,   0);
      check({tag, " en_acs"},  o_en_acs,      0);
      check({tag, " first"},   o_first_sym,   0);
      check({tag, " wr_en"},   o_mem_wr_en,   0);
      check({tag, " wr_addr"}, o_mem_wr_addr, 0);
      check({tag, " en_tb"},   o_en_tb,       0);
      check({tag, " tb_addr"}, o_tb_addr,     0);
      check({tag, " busy"},    o_busy,        0);
      check({tag, " done"},    o_done,        0);
   endtask

   // Runs one frame from the start request; stall cycles are counted from the
   // start-accept edge (cycle 0). disturb toggles i_start/i_frame_len mid-frame.
   task automatic run_frame(input int len, input int stall_a, input int stall_b,
                            input int exp_done_cyc, input bit disturb, input string tag);
      int cyc = 0;
      int idx = 0;
      @(negedge clk);
      i_start = 1'b1; i_frame_len = CNT_W'(len); i_sym_valid = 1'b0;
      #1 check({tag, " pre-start busy"}, o_busy, 0);
      while (idx < len && cyc < len + 16) begin
         @(negedge clk);
         cyc++;
         i_start     = disturb;
         i_frame_len = disturb ? CNT_W'($urandom_range(1, 255)) : CNT_W'(len);
         i_sym_valid = !(cyc == stall_a || cyc == stall_b);
         #1;
         check({tag, " acs ready"}, o_sym_ready, 1);
         check({tag, " acs busy"},  o_busy, 1);
         check({tag, " acs done"},  o_done, 0);
         check({tag, " acs en"},    o_en_acs, i_sym_valid);
         if (i_sym_valid) begin
            check({tag, " wr_en"},   o_mem_wr_en, 1);
            check({tag, " wr_addr"}, o_mem_wr_addr, idx);
            check({tag, " first"},   o_first_sym, (idx == 0));
            idx++;
         end
      end
      check({tag, " writes"}, idx, len);
      for (int f = 0; f < ACS_LAT; f++) begin
         @(negedge clk);
         cyc++;
         i_sym_valid = 1'b1;
         #1;
         check({tag, " flush ready"}, o_sym_ready, 0);
         check({tag, " flush en_acs"}, o_en_acs, 0);
         check({tag, " flush en_tb"}, o_en_tb, 0);
         check({tag, " flush busy"}, o_busy, 1);
      end
      for (int k = len - 1; k >= 0; k--) begin
         @(negedge clk);
         cyc++;
         i_start = disturb;
         #1;
         check({tag, " tb en"},     o_en_tb, 1);
         check({tag, " tb addr"},   o_tb_addr, k);
         check({tag, " tb en_acs"}, o_en_acs, 0);
         check({tag, " tb done"},   o_done, 0);
      end
      @(negedge clk);
      cyc++;
      i_start = 1'b0; i_sym_valid = 1'b0;
      #1;
      check({tag, " done"},      o_done, 1);
      check({tag, " done busy"}, o_busy, 1);
      check({tag, " done en_tb"}, o_en_tb, 0);
      check({tag, " done cycle"}, cyc, exp_done_cyc);
      @(negedge clk);
      #1;
      check({tag, " post done"}, o_done, 0);
      check({tag, " post busy"}, o_busy, 0);
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_frame_len = '0; i_sym_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_idle_outputs("reset");
      rst = 1'b0;

      // 1) len=4, no stalls: done at 4+1+4+1 = 10
      run_frame(4, -1, -1, 10, 1'b0, "t1");

      // 2) len=4, valid low on cycles 2 and 3: done at 12
      run_frame(4, 2, 3, 12, 1'b0, "t2");

      // 3) zero-length start ignored, then len=1: done at 1+1+1+1 = 4
      @(negedge clk);
      i_start = 1'b1; i_frame_len = '0;
      @(negedge clk);
      #1 check_idle_outputs("t3 len0");
      i_start = 1'b0;
      @(negedge clk);
      #1 check_idle_outputs("t3 len0 hold");
      run_frame(1, -1, -1, 4, 1'b0, "t3");

      // 4) start/len disturbed mid-frame, length 5 still used: done at 12
      run_frame(5, -1, -1, 12, 1'b1, "t4");

      // 5) reset during traceback, then a clean len=3 frame: done at 8
      @(negedge clk);
      i_start = 1'b1; i_frame_len = 8'd4;
      @(negedge clk);
      i_start = 1'b0; i_sym_valid = 1'b1;
      repeat (6) @(negedge clk);
      #1 check("t5 in tb", o_en_tb, 1);
      check("t5 tb addr", o_tb_addr, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 check_idle_outputs("t5 after rst");
      i_sym_valid = 1'b0;
      run_frame(3, -1, -1, 8, 1'b0, "t5");

      // 6) maximum frame: done at 255+1+255+1 = 512
      run_frame(255, -1, -1, 512, 1'b0, "t6");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
